module1_arg_loader: RTL



---
 rtl/module1_arg_loader_pkg.sv | 8 +
 rtl/module1_arg_loader_if.sv | 32 +++
 rtl/module1_arg_loader.sv | 98 +++++++++
 3 files changed

// File: rtl/module1_arg_loader_pkg.sv
// Shared constants and FSM encoding for the module1 argument loader.
package module1_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LD1 = 2'd1, LD2 = 2'd2, DONE = 2'd3} state_t;

  localparam int ARG1_OFFSET = 4;
  localparam int ARG1_SIZE   = 32;
  localparam int ARG2_SIZE   = 16;
endpackage

// File: rtl/module1_arg_loader_if.sv
// Memory daisy-chain bus: upstream (Min_*) request fields in, chained (Mout_*) fields out, read return.
interface module1_arg_loader_if #(
  parameter int ADDR_W  = 32,
  parameter int WDATA_W = 32,
  parameter int RDATA_W = 32,
  parameter int SIZE_W  = 7
);
  logic               Min_oe_ram;
  logic               Min_we_ram;
  logic [ADDR_W-1:0]  Min_addr_ram;
  logic [WDATA_W-1:0] Min_Wdata_ram;
  logic [SIZE_W-1:0]  Min_data_ram_size;
  logic               Mout_oe_ram;
  logic               Mout_we_ram;
  logic [ADDR_W-1:0]  Mout_addr_ram;
  logic [WDATA_W-1:0] Mout_Wdata_ram;
  logic [SIZE_W-1:0]  Mout_data_ram_size;
  logic [RDATA_W-1:0] M_Rdata_ram;
  logic               M_DataRdy;

  modport master (
    input  Min_oe_ram, Min_we_ram, Min_addr_ram, Min_Wdata_ram, Min_data_ram_size,
    input  M_Rdata_ram, M_DataRdy,
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size
  );

  modport slave (
    output Min_oe_ram, Min_we_ram, Min_addr_ram, Min_Wdata_ram, Min_data_ram_size,
    output M_Rdata_ram, M_DataRdy,
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size
  );
endinterface

// File: rtl/module1_arg_loader.sv
// Fetches input1 (32b at args) and input2 (16b at args+4) over the memory chain, then pulses done_port.
// Latency: done_port 3 cycles after start with zero-wait memory; each wait cycle adds one.
module module1_arg_loader
  import module1_pkg::*;
#(
  parameter int BITSIZE_args              = 32,
  parameter int BITSIZE_Min_addr_ram      = 32,
  parameter int BITSIZE_M_Rdata_ram       = 32,
  parameter int BITSIZE_Min_Wdata_ram     = 32,
  parameter int BITSIZE_Min_data_ram_size = 7
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start_port,
  input  logic [BITSIZE_args-1:0] args,
  output logic                    done_port,
  output logic                    busy,
  output logic [31:0]             input1_out,
  output logic [15:0]             input2_out,
  module1_arg_loader_if.master    mem
);
  localparam int AW = BITSIZE_Min_addr_ram;
  localparam int SW = BITSIZE_Min_data_ram_size;

  state_t                  state;
  logic [BITSIZE_args-1:0] base;
  logic [AW-1:0]           base_addr;
  logic                    own_oe;
  logic [AW-1:0]           own_addr;
  logic [SW-1:0]           own_size;

  assign base_addr = AW'(base);

  // Own request decodes the state register only, so reset drops it immediately.
  always_comb begin
    own_oe   = 1'b0;
    own_addr = '0;
    own_size = '0;
    case (state)
      LD1: begin
        own_oe   = 1'b1;
        own_addr = base_addr;
        own_size = SW'(ARG1_SIZE);
      end
      LD2: begin
        own_oe   = 1'b1;
        own_addr = base_addr + AW'(ARG1_OFFSET);
        own_size = SW'(ARG2_SIZE);
      end
      default: ;
    endcase
  end

  assign mem.Mout_oe_ram        = mem.Min_oe_ram | own_oe;
  assign mem.Mout_addr_ram      = mem.Min_addr_ram | own_addr;
  assign mem.Mout_data_ram_size = mem.Min_data_ram_size | own_size;
  assign mem.Mout_we_ram        = mem.Min_we_ram;
  assign mem.Mout_Wdata_ram     = mem.Min_Wdata_ram;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      base       <= '0;
      input1_out <= '0;
      input2_out <= '0;
      done_port  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done_port <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_port) begin
            state <= LD1;
            base  <= args;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        LD1: begin
          if (mem.M_DataRdy) begin
            input1_out <= mem.M_Rdata_ram[31:0];
            state      <= LD2;
          end
        end
        LD2: begin
          if (mem.M_DataRdy) begin
            input2_out <= mem.M_Rdata_ram[15:0];
            state      <= DONE;
            busy       <= 1'b0;
            done_port  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
